// File: rtl/ddr_rd_burst_feeder_pkg.sv
// Shared constants and FSM state type for the DDR read burst feeder.
// AXI encodings are fixed because every beat is a full 32-byte word.
package ddr_rd_pkg;

  localparam int         BEAT_BYTES   = 32;
  localparam logic [2:0] AXI_SIZE_32B = 3'b101;
  localparam logic [1:0] AXI_INCR     = 2'b01;
  localparam logic [1:0] RESP_OKAY    = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_DRAIN
  } rd_state_e;

endpackage

// File: rtl/ddr_rd_burst_feeder_if.sv
// AXI4 read address and read data channels between the feeder (master)
// and the DDR controller (slave).
interface ddr_rd_burst_feeder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
);

  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid;
  logic              m_arready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

  modport slave (
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready,
    output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid
  );

endinterface

// File: rtl/ddr_rd_burst_feeder_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is read
// asynchronously from the array so a push is visible on the next cycle.
module sync_fwft_fifo #(
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [DATA_W-1:0]              push_data,
  input  logic                           pop,
  output logic [DATA_W-1:0]              head_data,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(FIFO_DEPTH):0]    count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign count = count_q;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head_data = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ddr_rd_burst_feeder.sv
// DDR read engine: splits a byte-length job into 4 KB-safe AXI INCR bursts,
// admitting each burst only once FIFO space for all its beats is reserved.
module ddr_rd_burst_feeder
  import ddr_rd_pkg::*;
#(
  parameter int DDR_ADDR_LEN = 32,
  parameter int SINGLE_LEN   = 24,
  parameter int DATA_W       = 256,
  parameter int MAX_BURST    = 16,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ddr_conf,
  input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
  input  logic [SINGLE_LEN-1:0]   ddr_len,
  ddr_rd_burst_feeder_if.master   axi,
  output logic                    fifo_empty,
  input  logic                    fifo_req,
  output logic [DATA_W-1:0]       fifo_data,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_err
);

  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int BEATS_W    = SINGLE_LEN + 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int CRED_W     = CNT_W + 1;

  rd_state_e             state_q, state_d;
  logic [DDR_ADDR_LEN-1:0] addr_q, addr_d, m_araddr_q, m_araddr_d;
  logic [BEATS_W-1:0]    rem_beats_q, rem_beats_d, bl_q, bl_d;
  logic [7:0]            m_arlen_q, m_arlen_d;
  logic                  m_arvalid_q, m_arvalid_d, m_rready_q, m_rready_d;
  logic                  busy_q, busy_d, done_q, done_d, rd_err_q, rd_err_d;
  logic [CNT_W-1:0]      outstanding_q, outstanding_d;

  logic [BEATS_W-1:0]    len_ext, job_beats, page_beats, bl_calc;
  logic [12:0]           page_room;
  logic [CNT_W-1:0]      fifo_count;
  logic [CRED_W-1:0]     credit;
  logic                  push, ar_hs, fifo_full, unused_ok;

  assign axi.m_araddr  = m_araddr_q;
  assign axi.m_arlen   = m_arlen_q;
  assign axi.m_arsize  = AXI_SIZE_32B;
  assign axi.m_arburst = AXI_INCR;
  assign axi.m_arvalid = m_arvalid_q;
  assign axi.m_rready  = m_rready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign rd_err = rd_err_q;
  assign unused_ok = &{1'b0, axi.m_rlast, fifo_full};

  // Beats outside a job are acknowledged but never stored.
  assign push  = axi.m_rvalid && m_rready_q && busy_q;
  assign ar_hs = m_arvalid_q && axi.m_arready;

  assign len_ext    = {1'b0, ddr_len} + BEATS_W'(BEAT_BYTES - 1);
  assign job_beats  = len_ext >> BEAT_SHIFT;
  assign page_room  = 13'd4096 - {1'b0, addr_q[11:0]};
  assign page_beats = BEATS_W'(page_room >> BEAT_SHIFT);
  assign credit     = CRED_W'(FIFO_DEPTH) - CRED_W'(fifo_count) - CRED_W'(outstanding_q);
  assign m_rready_d = 1'b1;

  always_comb begin
    bl_calc = rem_beats_q;
    if (bl_calc > BEATS_W'(MAX_BURST)) bl_calc = BEATS_W'(MAX_BURST);
    if (bl_calc > page_beats)          bl_calc = page_beats;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (ar_hs) outstanding_d = outstanding_d + CNT_W'(bl_q);
    if (push)  outstanding_d = outstanding_d - CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_beats_d = rem_beats_q;
    bl_d        = bl_q;
    m_araddr_d  = m_araddr_q;
    m_arlen_d   = m_arlen_q;
    m_arvalid_d = m_arvalid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_err_d    = rd_err_q | (push && (axi.m_rresp != RESP_OKAY));
    case (state_q)
      ST_IDLE: begin
        if (ddr_conf) begin
          rd_err_d    = 1'b0;
          addr_d      = ddr_st_addr;
          rem_beats_d = job_beats;
          if (job_beats == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (BEATS_W'(credit) >= bl_calc) begin
          m_araddr_d  = addr_q;
          m_arlen_d   = 8'(bl_calc - BEATS_W'(1));
          m_arvalid_d = 1'b1;
          bl_d        = bl_calc;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (axi.m_arready) begin
          m_arvalid_d = 1'b0;
          addr_d      = addr_q + (DDR_ADDR_LEN'(bl_q) << BEAT_SHIFT);
          rem_beats_d = rem_beats_q - bl_q;
          state_d     = (rem_beats_q == bl_q) ? ST_DRAIN : ST_CALC;
        end
      end
      ST_DRAIN: begin
        if (outstanding_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      rem_beats_q   <= '0;
      bl_q          <= '0;
      m_araddr_q    <= '0;
      m_arlen_q     <= '0;
      m_arvalid_q   <= 1'b0;
      m_rready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_err_q      <= 1'b0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_beats_q   <= rem_beats_d;
      bl_q          <= bl_d;
      m_araddr_q    <= m_araddr_d;
      m_arlen_q     <= m_arlen_d;
      m_arvalid_q   <= m_arvalid_d;
      m_rready_q    <= m_rready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_err_q      <= rd_err_d;
      outstanding_q <= outstanding_d;
    end
  end

  sync_fwft_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (axi.m_rdata),
    .pop       (fifo_req),
    .head_data (fifo_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule
